// File: rtl/pc_sequencer.sv
// pc_sequencer: word-addressed program counter with next-PC selection
// (sequential, branch, jump, register jump) and an optional hardware
// return-address stack, built only when the macro PC_SEQ_RAS_EN is defined.
// Without it, ret behaves as jr and link is ignored.
module pc_sequencer #(
    parameter int              PC_W      = 32,
    parameter int              JADDR_W   = 26,
    parameter int              IMM_W     = 16,
    parameter logic [PC_W-1:0] RESET_PC  = '0,
    parameter int              RAS_DEPTH = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               stall,
    input  logic               branch_taken,
    input  logic [IMM_W-1:0]   branch_off,
    input  logic               jump,
    input  logic [JADDR_W-1:0] jump_addr,
    input  logic               link,
    input  logic               jr,
    input  logic               ret,
    input  logic [PC_W-1:0]    jr_target,
    output logic [PC_W-1:0]    pc,
    output logic [PC_W-1:0]    pc_plus1,
    output logic               ras_empty,
    output logic               ras_full,
    output logic               ras_ovf
);

    logic [PC_W-1:0] branch_target;
    logic [PC_W-1:0] jump_target;
    logic [PC_W-1:0] next_pc;
    logic [PC_W-1:0] ras_top;
    logic            ret_hit;   // ret served from the stack rather than jr_target

    assign pc_plus1      = pc + 1'b1;
    assign branch_target = pc_plus1 + PC_W'($signed(branch_off));
    assign jump_target   = {pc_plus1[PC_W-1:JADDR_W], jump_addr};

`ifdef PC_SEQ_RAS_EN
    localparam int PTR_W = $clog2(RAS_DEPTH);
    localparam int CNT_W = $clog2(RAS_DEPTH + 1);

    logic [PC_W-1:0]  ras_mem [RAS_DEPTH];
    logic [PTR_W-1:0] ptr;      // next free slot; top of stack is ptr-1
    logic [PTR_W-1:0] ptr_inc;
    logic [PTR_W-1:0] ptr_dec;
    logic [CNT_W-1:0] cnt;
    logic             ovf_q;
    logic             link_eff;
    logic             do_push;
    logic             do_pop;
    logic             do_replace;

    assign ptr_inc   = (ptr == PTR_W'(RAS_DEPTH - 1)) ? '0 : ptr + 1'b1;
    assign ptr_dec   = (ptr == '0) ? PTR_W'(RAS_DEPTH - 1) : ptr - 1'b1;
    assign ras_top   = ras_mem[ptr_dec];
    assign ras_empty = (cnt == '0);
    assign ras_full  = (cnt == CNT_W'(RAS_DEPTH));
    assign ras_ovf   = ovf_q;

    // link only counts alongside a jump; ret+link on a non-empty stack swaps the top in place
    assign link_eff   = link & (jump | jr);
    assign do_push    = link_eff & (~ret | ras_empty);
    assign do_replace = link_eff & ret & ~ras_empty;
    assign do_pop     = ret & ~ras_empty & ~link_eff;
    assign ret_hit    = ret & ~ras_empty;

    // Stack entries: written on push (overwriting the oldest when full) or top replacement
    // NOTE: entries carry no reset; count and pointer alone define validity, so storage stays plain RAM.
    always_ff @(posedge clk) begin
        if (!stall) begin
            if (do_push) begin
                ras_mem[ptr] <= pc_plus1;
            end else if (do_replace) begin
                ras_mem[ptr_dec] <= pc_plus1;
            end
        end
    end

    // Stack pointer, occupancy count and sticky overflow flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr   <= '0;
            cnt   <= '0;
            ovf_q <= 1'b0;
        end else if (!stall) begin
            if (do_push) begin
                ptr <= ptr_inc;
                if (ras_full) begin
                    ovf_q <= 1'b1;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end else if (do_pop) begin
                ptr <= ptr_dec;
                cnt <= cnt - 1'b1;
            end
        end
    end
`else
    logic unused_ras;

    assign ras_top    = '0;
    assign ret_hit    = 1'b0;
    assign ras_empty  = 1'b1;
    assign ras_full   = 1'b0;
    assign ras_ovf    = 1'b0;
    assign unused_ras = link & (RAS_DEPTH > 1);
`endif

    // Next-PC priority mux: ret, jr, jump, branch, sequential
    // NOTE: every branch assigns next_pc and a default is given first, so no latch can be inferred.
    always_comb begin
        next_pc = pc_plus1;
        if (ret_hit) begin
            next_pc = ras_top;
        end else if (ret || jr) begin
            next_pc = jr_target;
        end else if (jump) begin
            next_pc = jump_target;
        end else if (branch_taken) begin
            next_pc = branch_target;
        end
    end

    // PC register, held while stalled
    // NOTE: sequential state uses non-blocking assignment so all registers see pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc <= RESET_PC;
        end else if (!stall) begin
            pc <= next_pc;
        end
    end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Parametrised program-counter sequencer for the single-cycle core: holds the word-addressed PC register and selects the next PC each cycle from sequential, branch, jump (upper-PC concatenation), and register-jump targets. Optionally includes a hardware return-address stack (RAS) that is pushed on linking jumps and popped on returns. Sits between the decode/control stage, which supplies the targets and selects, and instruction memory, which is addressed by `pc`.

## Interface
- `PC_W`, 32: PC width in bits. The PC is word-addressed.
- `JADDR_W`, 26: jump-immediate width. Must be less than `PC_W`.
- `IMM_W`, 16: branch-offset width. The offset is signed and counted in words.
- `RESET_PC`, 0: PC value loaded on reset.
- `RAS_DEPTH`, 4: number of RAS entries. Must be at least 2. Used only with `RAS_EN`.

- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  asynchronous reset, active low
- `stall`  in  1  hold PC and RAS this cycle
- `branch_taken`  in  1  take the branch target
- `branch_off`  in  IMM_W  signed word offset
- `jump`  in  1  take the concatenated jump target
- `jump_addr`  in  JADDR_W  jump immediate
- `link`  in  1  linking jump: push `pc_plus1` onto the RAS
- `jr`  in  1  jump to `jr_target`
- `ret`  in  1  return: pop the RAS
- `jr_target`  in  PC_W  register-jump target
- `pc`  out  PC_W  current PC
- `pc_plus1`  out  PC_W  `pc + 1`, combinational
- `ras_empty`  out  1  RAS holds no entries
- `ras_full`  out  1  RAS holds `RAS_DEPTH` entries
- `ras_ovf`  out  1  sticky flag: a push occurred while the RAS was full

## Operation
- **Sequential target:** `pc_plus1` = `pc + 1`, modulo 2^PC_W.
- **Branch target:** `pc_plus1` plus `branch_off` sign-extended to `PC_W`, modulo 2^PC_W.
- **Jump target:** `{pc_plus1[PC_W-1:JADDR_W], jump_addr}`.
- **Next-PC priority:**
  1. `ret`: RAS top if the RAS is non-empty, else `jr_target`.
  2. `jr`: `jr_target`.
  3. `jump`: jump target.
  4. `branch_taken`: branch target.
  5. Otherwise: `pc_plus1`.
- **RAS push:** `link` without `ret` pushes `pc_plus1`. `link` takes effect only when `jump` or `jr` is also asserted; `link` alone is ignored.
- **Push when full:** the oldest entry is discarded (circular buffer), the count stays at `RAS_DEPTH`, and `ras_ovf` is set.
- **RAS pop:** `ret` pops only when the RAS is non-empty. `ret` with the RAS empty causes no state change and the PC goes to `jr_target`.
- **`ret` and `link` together:** the top entry is replaced by `pc_plus1`; the count is unchanged. The next PC is the old top. If the RAS is empty, this acts as a plain push.
- **Stall:** `stall` = 1 blocks every state update (PC, RAS, `ras_ovf`). Outputs stay consistent with the held state.
- **Storage:** top-of-stack pointer of width `$clog2(RAS_DEPTH)`, wrapping modulo `RAS_DEPTH`, plus a count from 0 to `RAS_DEPTH`.

## Timing
- `pc` updates on the rising edge of `clk` to the selected next PC; the target is visible in the cycle after the control inputs are presented.
- The next-PC mux is combinational from the inputs and current state, so the core sees zero-cycle latency from control to target selection.
- `pc_plus1`, `ras_empty` and `ras_full` are combinational from state. `ras_ovf` is registered.
- **Reset:** asynchronous, `rst_n` = 0. Sets `pc` = `RESET_PC`, RAS count = 0, pointer = 0, `ras_ovf` = 0. Outputs during reset: `ras_empty` = 1, `ras_full` = 0, `pc_plus1` = `RESET_PC + 1`.
- **Reset mid-operation:** assertion clears state immediately, regardless of `clk`. Entry contents are don't-care after reset.
- **Release of `rst_n`:** the first rising edge after release performs a normal update.

## Configuration
- Macro `PC_SEQ_RAS_EN`.
- **Defined:** the RAS, its storage and its pointer are built, and `ret` behaves as described in Operation.
- **Undefined:** no RAS storage is built.
  - `ret` behaves exactly as `jr`.
  - `link` is ignored.
  - `ras_empty` is tied to 1; `ras_full` and `ras_ovf` are tied to 0.
  - `RAS_DEPTH` is unused.

## Test plan
- **Reset and sequential run:** `RESET_PC` = 0x100; release reset with no controls asserted → `pc` reads 0x100, 0x101, 0x102 on successive edges. Assert `rst_n` = 0 mid-cycle → `pc` = 0x100 immediately.
- **Branch and jump targets:** at `pc` = 0x0000_0010, `branch_off` = 0xFFFE → next `pc` = 0x0F. At `pc` = 0xA000_0004, `jump_addr` = 0x0000123 → next `pc` = 0xA000_0123. Assert `jump` and `branch_taken` together → jump target wins.
- **Call/return:** JAL (`jump` + `link`) at `pc` = 0x20 → RAS top = 0x21. Then `ret` with `jr_target` = 0x999 → next `pc` = 0x21 and `ras_empty` = 1. A second `ret` → next `pc` = 0x999.
- **Overflow:** with `RAS_DEPTH` = 4, perform five pushes of A, B, C, D, E → `ras_full` = 1 and `ras_ovf` = 1. Four pops return E, D, C, B; then `ras_empty` = 1.
- **Stall and simultaneous events:** `stall` = 1 together with `jump` + `link` → `pc` and RAS count unchanged. With top = 0x50, `ret` + `jr` + `link` at `pc` = 0x70 → next `pc` = 0x50, top = 0x71, count unchanged.
- **`PC_SEQ_RAS_EN` undefined:** JAL followed by `ret` with `jr_target` = 0x40 → next `pc` = 0x40, and `ras_empty` stays 1 throughout.
